// File: rtl/uart_parity_core_if.sv
// Signal bundle for uart_parity_core: line config, serial pins,
// RX FIFO read side and TX FIFO write side.
interface uart_parity_core_if #(
    parameter int DBIT   = 8,
    parameter int BAUD_W = 11
);
    logic [BAUD_W-1:0] baud_div;
    logic              parity_en;
    logic              parity_odd;
    logic              stop2;
    logic              rx;
    logic              rd_uart;
    logic              clr_err;
    logic [DBIT-1:0]   w_data;
    logic              wr_uart;
    logic [DBIT-1:0]   r_data;
    logic              r_perr;
    logic              r_ferr;
    logic              rx_empty;
    logic              rx_overrun;
    logic              tx_full;
    logic              tx;
    logic              tx_idle;

    modport master (
        output baud_div, parity_en, parity_odd, stop2,
        output rx, rd_uart, clr_err, w_data, wr_uart,
        input  r_data, r_perr, r_ferr, rx_empty,
        input  rx_overrun, tx_full, tx, tx_idle
    );

    modport slave (
        input  baud_div, parity_en, parity_odd, stop2,
        input  rx, rd_uart, clr_err, w_data, wr_uart,
        output r_data, r_perr, r_ferr, rx_empty,
        output rx_overrun, tx_full, tx, tx_idle
    );
endinterface

// File: rtl/uart_parity_core.sv
// UART with optional parity, 1/2 stop bits and first-word-fall-through
// FIFOs in both directions; one oversampling tick paces RX and TX.
module uart_parity_core_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         wr_ok;
    logic         rd_ok;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_ok  = rd && !empty;
    assign wr_ok  = wr && (!full || rd);
    assign r_data = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            mem_d[wptr_q[AW-1:0]] = w_data;
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
endmodule

module uart_parity_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 4,
    parameter int BAUD_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BAUD_W-1:0] baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic              rx,
    input  logic              rd_uart,
    output logic [DBIT-1:0]   r_data,
    output logic              r_perr,
    output logic              r_ferr,
    output logic              rx_empty,
    output logic              rx_overrun,
    input  logic              clr_err,
    input  logic [DBIT-1:0]   w_data,
    input  logic              wr_uart,
    output logic              tx_full,
    output logic              tx,
    output logic              tx_idle
);
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    localparam int SW = $clog2(2 * SB_TICK + 16);
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_SB1  = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_SB2  = SW'(2 * SB_TICK - 1);
    localparam logic [3:0]    N_LAST = 4'(DBIT - 1);

    logic [BAUD_W-1:0] tcnt_q, tcnt_d;
    logic              tick;

    state_t          rx_state_q, rx_state_d;
    logic [SW-1:0]   rx_s_q, rx_s_d;
    logic [3:0]      rx_n_q, rx_n_d;
    logic [DBIT-1:0] rx_b_q, rx_b_d;
    logic            rx_pen_q, rx_pen_d;
    logic            rx_podd_q, rx_podd_d;
    logic            rx_perr_q, rx_perr_d;
    logic            ovr_q, ovr_d;
    logic            rx_wr;
    logic            rx_ferr;

    logic [DBIT+1:0] rxf_rdata;
    logic            rxf_empty;
    logic            rxf_full;

    state_t          tx_state_q, tx_state_d;
    logic [SW-1:0]   tx_s_q, tx_s_d;
    logic [3:0]      tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_sh_q, tx_sh_d;
    logic            tx_pbit_q, tx_pbit_d;
    logic            tx_pen_q, tx_pen_d;
    logic            tx_st2_q, tx_st2_d;
    logic            tx_load;

    logic [DBIT-1:0] txf_rdata;
    logic            txf_empty;
    logic            txf_full;

    // ">=" keeps ticking if baud_div shrinks below the running count.
    assign tick = (tcnt_q >= baud_div);

    always_comb begin
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_pen_d   = rx_pen_q;
        rx_podd_d  = rx_podd_q;
        rx_perr_d  = rx_perr_q;
        rx_wr      = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            IDLE: begin
                if (!rx) begin
                    rx_state_d = START;
                    rx_s_d     = '0;
                    rx_pen_d   = parity_en;
                    rx_podd_d  = parity_odd;
                    rx_perr_d  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q == S_MID) begin
                        rx_s_d     = '0;
                        rx_n_d     = '0;
                        rx_state_d = rx ? IDLE : DATA;
                    end else begin
                        rx_s_d = rx_s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s_q == S_BIT) begin
                        rx_s_d = '0;
                        rx_b_d = {rx, rx_b_q[DBIT-1:1]};
                        if (rx_n_q == N_LAST) begin
                            rx_state_d = rx_pen_q ? PARITY : STOP;
                        end else begin
                            rx_n_d = rx_n_q + 1'b1;
                        end
                    end else begin
                        rx_s_d = rx_s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (rx_s_q == S_BIT) begin
                        rx_s_d     = '0;
                        rx_perr_d  = ^rx_b_q ^ rx ^ rx_podd_q;
                        rx_state_d = STOP;
                    end else begin
                        rx_s_d = rx_s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s_q == S_SB1) begin
                        rx_wr      = 1'b1;
                        rx_ferr    = !rx;
                        rx_state_d = IDLE;
                    end else begin
                        rx_s_d = rx_s_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // A dropped word sets overrun even if clr_err is pulsed the same clk.
    always_comb begin
        ovr_d = ovr_q;
        if (clr_err) begin
            ovr_d = 1'b0;
        end
        if (rx_wr && rxf_full && !rd_uart) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_sh_d    = tx_sh_q;
        tx_pbit_d  = tx_pbit_q;
        tx_pen_d   = tx_pen_q;
        tx_st2_d   = tx_st2_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            IDLE: tx_load = !txf_empty;
            START: begin
                if (tick) begin
                    if (tx_s_q == S_BIT) begin
                        tx_s_d     = '0;
                        tx_n_d     = '0;
                        tx_state_d = DATA;
                    end else begin
                        tx_s_d = tx_s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_s_q == S_BIT) begin
                        tx_s_d  = '0;
                        tx_sh_d = tx_sh_q >> 1;
                        if (tx_n_q == N_LAST) begin
                            tx_state_d = tx_pen_q ? PARITY : STOP;
                        end else begin
                            tx_n_d = tx_n_q + 1'b1;
                        end
                    end else begin
                        tx_s_d = tx_s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tx_s_q == S_BIT) begin
                        tx_s_d     = '0;
                        tx_state_d = STOP;
                    end else begin
                        tx_s_d = tx_s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_s_q == (tx_st2_q ? S_SB2 : S_SB1)) begin
                        tx_state_d = IDLE;
                        tx_load    = !txf_empty;
                    end else begin
                        tx_s_d = tx_s_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = IDLE;
        endcase
        // Frame config is frozen at pop so mid-frame changes are ignored.
        if (tx_load) begin
            tx_state_d = START;
            tx_s_d     = '0;
            tx_sh_d    = txf_rdata;
            tx_pbit_d  = ^txf_rdata ^ parity_odd;
            tx_pen_d   = parity_en;
            tx_st2_d   = stop2;
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (tx_state_q)
            START:   tx = 1'b0;
            DATA:    tx = tx_sh_q[0];
            PARITY:  tx = tx_pbit_q;
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q     <= '0;
            rx_state_q <= IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_pen_q   <= 1'b0;
            rx_podd_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            ovr_q      <= 1'b0;
            tx_state_q <= IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_sh_q    <= '0;
            tx_pbit_q  <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_st2_q   <= 1'b0;
        end else begin
            tcnt_q     <= tcnt_d;
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
            rx_pen_q   <= rx_pen_d;
            rx_podd_q  <= rx_podd_d;
            rx_perr_q  <= rx_perr_d;
            ovr_q      <= ovr_d;
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_sh_q    <= tx_sh_d;
            tx_pbit_q  <= tx_pbit_d;
            tx_pen_q   <= tx_pen_d;
            tx_st2_q   <= tx_st2_d;
        end
    end

    uart_parity_core_fifo #(
        .W  (DBIT + 2),
        .AW (FIFO_AW)
    ) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_wr),
        .rd     (rd_uart),
        .w_data ({rx_ferr, rx_perr_q, rx_b_q}),
        .r_data (rxf_rdata),
        .empty  (rxf_empty),
        .full   (rxf_full)
    );

    uart_parity_core_fifo #(
        .W  (DBIT),
        .AW (FIFO_AW)
    ) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_uart),
        .rd     (tx_load),
        .w_data (w_data),
        .r_data (txf_rdata),
        .empty  (txf_empty),
        .full   (txf_full)
    );

    assign rx_empty   = rxf_empty;
    assign rx_overrun = ovr_q;
    assign r_data     = rxf_empty ? '0 : rxf_rdata[DBIT-1:0];
    assign r_perr     = rxf_empty ? 1'b0 : rxf_rdata[DBIT];
    assign r_ferr     = rxf_empty ? 1'b0 : rxf_rdata[DBIT+1];
    assign tx_full    = txf_full;
    assign tx_idle    = (tx_state_q == IDLE) && txf_empty;
endmodule

// File: tb/tb_uart_parity_core.sv
// Bench for uart_parity_core: table of injected RX frames, directed
// corner sequences and random loopback frames against a waveform model.
module tb_uart_parity_core;
    localparam int DBIT   = 8;
    localparam int BAUD_W = 11;

    typedef struct {
        logic [7:0] d;
        bit         pen;
        bit         podd;
        bit         pbit;
        bit         stopv;
        bit         perr;
        bit         ferr;
    } rxvec_t;

    logic clk = 1'b0;
    logic reset;
    logic loop_en;
    logic rx_drv;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   wave_q[$];

    always #5 clk = ~clk;

    uart_parity_core_if #(.DBIT(DBIT), .BAUD_W(BAUD_W)) ifc ();

    assign ifc.rx = loop_en ? ifc.tx : rx_drv;

    uart_parity_core #(
        .DBIT    (DBIT),
        .SB_TICK (16),
        .FIFO_AW (4),
        .BAUD_W  (BAUD_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_div   (ifc.baud_div),
        .parity_en  (ifc.parity_en),
        .parity_odd (ifc.parity_odd),
        .stop2      (ifc.stop2),
        .rx         (ifc.rx),
        .rd_uart    (ifc.rd_uart),
        .r_data     (ifc.r_data),
        .r_perr     (ifc.r_perr),
        .r_ferr     (ifc.r_ferr),
        .rx_empty   (ifc.rx_empty),
        .rx_overrun (ifc.rx_overrun),
        .clr_err    (ifc.clr_err),
        .w_data     (ifc.w_data),
        .wr_uart    (ifc.wr_uart),
        .tx_full    (ifc.tx_full),
        .tx         (ifc.tx),
        .tx_idle    (ifc.tx_idle)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, required $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        ifc.w_data  = d;
        ifc.wr_uart = 1'b1;
        @(negedge clk);
        ifc.wr_uart = 1'b0;
    endtask

    task automatic inject(input logic [7:0] d, input bit pen,
                          input bit pbit, input bit stopv);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (16) @(negedge clk);
        end
        rx_drv = stopv;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pop_check(input string nm, input logic [7:0] d,
                             input bit perr, input bit ferr,
                             input int limit);
        int w = 0;
        while (ifc.rx_empty && w < limit) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_ready"}, ifc.rx_empty, 0);
        check({nm, "_word"}, {ifc.r_ferr, ifc.r_perr, ifc.r_data},
              {ferr, perr, d});
        ifc.rd_uart = 1'b1;
        @(negedge clk);
        ifc.rd_uart = 1'b0;
    endtask

    // Expected line level per clk (baud_div = 0, 16 clk per bit).
    task automatic tx_frame(input string nm, input logic [7:0] d,
                            input bit pen, input bit podd,
                            input bit st2, input bit strict);
        int w = 0;
        int errs = 0;
        int ones;
        ones = $countones(d);
        wave_q.delete();
        repeat (16) wave_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) wave_q.push_back(d[i]);
        end
        if (pen) begin
            repeat (16) wave_q.push_back(bit'((ones + int'(podd)) % 2));
        end
        repeat (st2 ? 32 : 16) wave_q.push_back(1'b1);
        @(negedge clk);
        while (ifc.tx !== 1'b0 && !strict && w < 400) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_start"}, ifc.tx, 0);
        if (ifc.tx === 1'b0) begin
            for (int i = 0; i < wave_q.size(); i++) begin
                if (i > 0) @(negedge clk);
                if (ifc.tx !== wave_q[i]) errs++;
            end
            check({nm, "_wave"}, errs, 0);
        end
    endtask

    task automatic reset_mid(input string nm, input logic [7:0] d);
        int w = 0;
        loop_en = 1'b1;
        ifc.parity_en = 1'b0;
        ifc.stop2 = 1'b0;
        write_tx(d);
        while (ifc.tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (56) @(negedge clk);
        check({nm, "_busy"}, ifc.tx_idle, 0);
        reset = 1'b1;
        @(negedge clk);
        check({nm, "_tx"}, ifc.tx, 1);
        check({nm, "_txidle"}, ifc.tx_idle, 1);
        check({nm, "_rxempty"}, ifc.rx_empty, 1);
        check({nm, "_txfull"}, ifc.tx_full, 0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check({nm, "_nostray"}, ifc.rx_empty, 1);
        check({nm, "_quiet"}, {ifc.tx, ifc.tx_idle}, 2'b11);
    endtask

    initial begin
        rxvec_t     tbl[10];
        logic [7:0] txv[17];
        logic [7:0] ovd[17];
        logic [10:0] got_pat;
        logic [7:0] rd;
        bit         rpen, rpodd, rst2;
        int         w, cnt;

        tbl[0] = '{8'hA5, 1, 0, 0, 1, 0, 0};
        tbl[1] = '{8'h3C, 1, 1, 0, 1, 1, 0};
        tbl[2] = '{8'h3C, 1, 1, 1, 1, 0, 0};
        tbl[3] = '{8'h07, 1, 0, 0, 1, 1, 0};
        tbl[4] = '{8'h07, 1, 0, 1, 1, 0, 0};
        tbl[5] = '{8'h80, 1, 1, 0, 1, 0, 0};
        tbl[6] = '{8'hFF, 0, 0, 0, 1, 0, 0};
        tbl[7] = '{8'h00, 1, 1, 1, 1, 0, 0};
        tbl[8] = '{8'h00, 1, 0, 1, 1, 1, 0};
        tbl[9] = '{8'h55, 0, 0, 0, 0, 0, 1};

        reset          = 1'b1;
        loop_en        = 1'b0;
        rx_drv         = 1'b1;
        ifc.baud_div   = '0;
        ifc.parity_en  = 1'b0;
        ifc.parity_odd = 1'b0;
        ifc.stop2      = 1'b0;
        ifc.rd_uart    = 1'b0;
        ifc.clr_err    = 1'b0;
        ifc.wr_uart    = 1'b0;
        ifc.w_data     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_tx", ifc.tx, 1);
        check("rst_tx_idle", ifc.tx_idle, 1);
        check("rst_rx_empty", ifc.rx_empty, 1);
        check("rst_tx_full", ifc.tx_full, 0);
        check("rst_overrun", ifc.rx_overrun, 0);
        check("rst_rword", {ifc.r_ferr, ifc.r_perr, ifc.r_data}, 0);

        for (int i = 0; i < 10; i++) begin
            ifc.parity_en  = tbl[i].pen;
            ifc.parity_odd = tbl[i].podd;
            inject(tbl[i].d, tbl[i].pen, tbl[i].pbit, tbl[i].stopv);
            pop_check($sformatf("tbl%0d", i), tbl[i].d,
                      tbl[i].perr, tbl[i].ferr, 40);
            check($sformatf("tbl%0d_single", i), ifc.rx_empty, 1);
        end

        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_nowrite", ifc.rx_empty, 1);

        loop_en        = 1'b1;
        ifc.parity_en  = 1'b1;
        ifc.parity_odd = 1'b0;
        ifc.stop2      = 1'b0;
        write_tx(8'hA5);
        w = 0;
        while (ifc.tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        got_pat = '0;
        for (int i = 0; i < 11; i++) begin
            repeat (i == 0 ? 8 : 16) @(negedge clk);
            got_pat[10-i] = ifc.tx;
        end
        check("a5_pattern", got_pat, 11'b01010010101);
        pop_check("a5_rx", 8'hA5, 0, 0, 200);
        repeat (20) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            rd    = 8'($urandom);
            rpen  = 1'($urandom);
            rpodd = 1'($urandom);
            rst2  = 1'($urandom);
            ifc.parity_en  = rpen;
            ifc.parity_odd = rpodd;
            ifc.stop2      = rst2;
            write_tx(rd);
            fork
                tx_frame($sformatf("rnd%0d", k), rd, rpen, rpodd, rst2, 0);
                begin
                    repeat (40) @(negedge clk);
                    ifc.parity_en  = 1'($urandom);
                    ifc.parity_odd = 1'($urandom);
                    ifc.stop2      = 1'($urandom);
                end
            join
            pop_check($sformatf("rnd%0d_rx", k), rd, 0, 0, 40);
        end

        ifc.baud_div   = 11'd3;
        ifc.parity_en  = 1'b1;
        ifc.parity_odd = 1'b1;
        ifc.stop2      = 1'b0;
        write_tx(8'h96);
        w = 0;
        while (ifc.tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        w = 0;
        while (ifc.tx !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        cnt = 0;
        while (ifc.tx === 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("baud3_two_bits", cnt, 128);
        pop_check("baud3_rx", 8'h96, 0, 0, 1000);
        ifc.baud_div = '0;
        repeat (100) @(negedge clk);

        loop_en = 1'b0;
        ifc.parity_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ovd[i] = 8'($urandom);
            inject(ovd[i], 0, 0, 1);
            if (i == 15) check("ovr_not_yet", ifc.rx_overrun, 0);
        end
        check("ovr_set", ifc.rx_overrun, 1);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("ovr_pop%0d", i), ovd[i], 0, 0, 1);
        end
        check("ovr_drained", ifc.rx_empty, 1);
        check("ovr_empty_word", {ifc.r_ferr, ifc.r_perr, ifc.r_data}, 0);
        check("ovr_sticky", ifc.rx_overrun, 1);
        ifc.clr_err = 1'b1;
        @(negedge clk);
        ifc.clr_err = 1'b0;
        check("ovr_cleared", ifc.rx_overrun, 0);

        ifc.parity_en  = 1'b1;
        ifc.parity_odd = 1'b0;
        ifc.stop2      = 1'b1;
        for (int i = 0; i < 17; i++) txv[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    ifc.wr_uart = 1'b1;
                    ifc.w_data  = txv[i];
                    @(negedge clk);
                end
                ifc.wr_uart = 1'b0;
                check("burst_full", ifc.tx_full, 1);
                write_tx(8'hEE);
                check("burst_still_full", ifc.tx_full, 1);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    tx_frame($sformatf("burst%0d", i), txv[i], 1, 0, 1,
                             i > 0);
                end
            end
        join
        @(negedge clk);
        check("burst_idle", {ifc.tx_idle, ifc.tx}, 2'b11);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (ifc.tx !== 1'b1) cnt++;
        end
        check("burst_no_extra", cnt, 0);
        ifc.stop2 = 1'b0;

        inject(8'h5A, 0, 0, 1);
        check("pending_before_rst", ifc.rx_empty, 0);
        reset_mid("rst_ff", 8'hFF);
        reset_mid("rst_00", 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
